// File: rtl/tick_sched_pkg.sv
// =====================================================================
// tick_sched_pkg : shared types, mode encodings and round-robin helper
// Rev 1.0
// =====================================================================
`default_nettype none

package tick_sched_pkg;

    localparam logic MODE_ONESHOT  = 1'b0;
    localparam logic MODE_PERIODIC = 1'b1;
    localparam int   MAX_CH        = 16;

    typedef enum logic [0:0] {
        CH_IDLE = 1'b0,
        CH_RUN  = 1'b1
    } ch_state_t;

    // First set bit of req at or after ptr, wrapping within n entries.
    // Returns ptr when req is empty; callers only use the result when req != 0.
    function automatic int rr_pick(input logic [MAX_CH-1:0] req, input int ptr, input int n);
        int idx;
        rr_pick = ptr;
        for (int k = MAX_CH - 1; k >= 0; k--) begin
            if (k < n) begin
                idx = ptr + k;
                if (idx >= n) idx = idx - n;
                if (req[idx]) rr_pick = idx;
            end
        end
    endfunction

endpackage

`default_nettype wire

// File: rtl/tick_channel.sv
// =====================================================================
// tick_channel : one software timer (period/mode registers, countdown)
// Rev 1.0
// =====================================================================
`default_nettype none

module tick_channel
    import tick_sched_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick_i,
    input  logic             cfg_we_i,
    input  logic [CNT_W-1:0] cfg_period_i,
    input  logic             cfg_mode_i,
    input  logic             start_i,
    input  logic             stop_i,
    output logic             busy_o,
    output logic             expire_o
);

    localparam logic [CNT_W-1:0] C_ONE = CNT_W'(1);

    ch_state_t        state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic             mode_q, mode_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= CH_IDLE;
            count_q  <= '0;
            period_q <= '0;
            mode_q   <= MODE_ONESHOT;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            period_q <= period_d;
            mode_q   <= mode_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        expire_o = 1'b0;
        period_d = cfg_we_i ? cfg_period_i : period_q;
        mode_d   = cfg_we_i ? cfg_mode_i : mode_q;

        // Priority: stop, then (re)start, then counting; a start masks that cycle's tick.
        if (stop_i) begin
            state_d = CH_IDLE;
            count_d = '0;
        end else if (start_i) begin
            if (period_q != '0) begin
                state_d = CH_RUN;
                count_d = period_q;
            end else begin
                state_d = CH_IDLE;
                count_d = '0;
            end
        end else if (state_q == CH_RUN && tick_i) begin
            if (count_q > C_ONE) begin
                count_d = count_q - C_ONE;
            end else begin
                expire_o = 1'b1;
                if (mode_q == MODE_PERIODIC && period_q != '0) begin
                    count_d = period_q;
                end else begin
                    state_d = CH_IDLE;
                    count_d = '0;
                end
            end
        end
    end

    assign busy_o = (state_q == CH_RUN);

endmodule

`default_nettype wire

// File: rtl/tick_scheduler.sv
// =====================================================================
// tick_scheduler : NUM_CH timers sharing one base tick, round-robin events
// Rev 1.0
// =====================================================================
`default_nettype none

module tick_scheduler
    import tick_sched_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 16,
    parameter int CH_W   = $clog2(NUM_CH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tick_in,
    input  logic              cfg_we,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_period,
    input  logic              cfg_mode,
    input  logic [NUM_CH-1:0] start,
    input  logic [NUM_CH-1:0] stop,
    output logic [NUM_CH-1:0] busy,
    output logic              evt_valid,
    output logic [CH_W-1:0]   evt_ch,
    input  logic              evt_ready,
    output logic [NUM_CH-1:0] overrun,
    input  logic              overrun_clr
);

    logic [NUM_CH-1:0] w_expire;
    logic [NUM_CH-1:0] pending_q, pending_d;
    logic [NUM_CH-1:0] overrun_q, overrun_d;
    logic              evt_valid_q, evt_valid_d;
    logic [CH_W-1:0]   evt_ch_q, evt_ch_d;
    logic [CH_W-1:0]   rr_q, rr_d;

    logic [MAX_CH-1:0] w_req_pad;
    logic              w_slot_free;
    logic              w_load;
    logic [CH_W-1:0]   w_sel;
    logic [NUM_CH-1:0] w_load_oh;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        tick_channel #(
            .CNT_W (CNT_W)
        ) u_ch (
            .clk          (clk),
            .rst          (rst),
            .tick_i       (tick_in),
            .cfg_we_i     (cfg_we && (cfg_ch == CH_W'(i))),
            .cfg_period_i (cfg_period),
            .cfg_mode_i   (cfg_mode),
            .start_i      (start[i]),
            .stop_i       (stop[i]),
            .busy_o       (busy[i]),
            .expire_o     (w_expire[i])
        );
    end

    always_comb begin
        w_req_pad              = '0;
        w_req_pad[NUM_CH-1:0]  = pending_q;
        w_slot_free            = !evt_valid_q || evt_ready;
        w_load                 = w_slot_free && (|pending_q);
        w_sel                  = CH_W'(rr_pick(w_req_pad, int'(rr_q), NUM_CH));
        w_load_oh              = w_load ? (NUM_CH'(1) << w_sel) : '0;

        // A fresh expiry re-arms a bit being drained this cycle; stop drops it outright.
        pending_d = ((pending_q & ~w_load_oh) | w_expire) & ~stop;
        overrun_d = (overrun_clr ? '0 : overrun_q) | (w_expire & pending_q & ~w_load_oh);

        evt_valid_d = evt_valid_q;
        evt_ch_d    = evt_ch_q;
        rr_d        = rr_q;
        if (w_load) begin
            evt_valid_d = 1'b1;
            evt_ch_d    = w_sel;
            rr_d        = (int'(w_sel) == NUM_CH - 1) ? '0 : w_sel + CH_W'(1);
        end else if (w_slot_free) begin
            evt_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending_q   <= '0;
            overrun_q   <= '0;
            evt_valid_q <= 1'b0;
            evt_ch_q    <= '0;
            rr_q        <= '0;
        end else begin
            pending_q   <= pending_d;
            overrun_q   <= overrun_d;
            evt_valid_q <= evt_valid_d;
            evt_ch_q    <= evt_ch_d;
            rr_q        <= rr_d;
        end
    end

    assign evt_valid = evt_valid_q;
    assign evt_ch    = evt_ch_q;
    assign overrun   = overrun_q;

endmodule

`default_nettype wire

// File: tb/tb_tick_scheduler.sv
// =====================================================================
// tb_tick_scheduler : directed stimulus with a cycle-level reference model
// Rev 1.0
// =====================================================================
`default_nettype none

module tb_tick_scheduler;

    localparam int N   = 4;
    localparam int CW  = 16;
    localparam int CHW = 2;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           tick_in = 1'b0;
    logic           cfg_we = 1'b0;
    logic [CHW-1:0] cfg_ch = '0;
    logic [CW-1:0]  cfg_period = '0;
    logic           cfg_mode = 1'b0;
    logic [N-1:0]   start = '0;
    logic [N-1:0]   stop = '0;
    logic           evt_ready = 1'b0;
    logic           overrun_clr = 1'b0;
    logic [N-1:0]   busy;
    logic           evt_valid;
    logic [CHW-1:0] evt_ch;
    logic [N-1:0]   overrun;

    tick_scheduler #(.NUM_CH(N), .CNT_W(CW), .CH_W(CHW)) dut (
        .clk         (clk),
        .rst         (rst),
        .tick_in     (tick_in),
        .cfg_we      (cfg_we),
        .cfg_ch      (cfg_ch),
        .cfg_period  (cfg_period),
        .cfg_mode    (cfg_mode),
        .start       (start),
        .stop        (stop),
        .busy        (busy),
        .evt_valid   (evt_valid),
        .evt_ch      (evt_ch),
        .evt_ready   (evt_ready),
        .overrun     (overrun),
        .overrun_clr (overrun_clr)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;
    bit chk_en = 1'b0;
    int ev_ch[$];
    int ev_cyc[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Reference model: remaining-tick counters per timer, a set of pending
    // channels, a one-entry output slot and a rotating search start.
    bit m_run[N];
    int m_rem[N];
    int m_per[N];
    bit m_mode[N];
    bit m_pend[N];
    bit m_ovr[N];
    bit m_exp[N];
    bit m_valid;
    int m_ch;
    int m_rr;

    task automatic model_step();
        int pick;
        bit free;
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                m_run[i] = 0; m_rem[i] = 0; m_per[i] = 0; m_mode[i] = 0;
                m_pend[i] = 0; m_ovr[i] = 0;
            end
            m_valid = 0; m_ch = 0; m_rr = 0;
            return;
        end
        pick = -1;
        free = !m_valid || evt_ready;
        if (free)
            for (int k = 0; k < N; k++)
                if (pick < 0 && m_pend[(m_rr + k) % N]) pick = (m_rr + k) % N;
        for (int i = 0; i < N; i++) begin
            m_exp[i] = 0;
            if (stop[i]) begin
                m_run[i] = 0; m_rem[i] = 0;
            end else if (start[i]) begin
                m_run[i] = (m_per[i] != 0); m_rem[i] = m_per[i];
            end else if (m_run[i] && tick_in) begin
                m_rem[i] = m_rem[i] - 1;
                if (m_rem[i] == 0) begin
                    m_exp[i] = 1;
                    if (m_mode[i] && m_per[i] != 0) m_rem[i] = m_per[i];
                    else m_run[i] = 0;
                end
            end
        end
        if (cfg_we) begin
            m_per[int'(cfg_ch)]  = int'(cfg_period);
            m_mode[int'(cfg_ch)] = cfg_mode;
        end
        if (overrun_clr) for (int i = 0; i < N; i++) m_ovr[i] = 0;
        for (int i = 0; i < N; i++)
            if (m_exp[i] && m_pend[i] && pick != i) m_ovr[i] = 1;
        for (int i = 0; i < N; i++) begin
            if (stop[i]) m_pend[i] = 0;
            else if (m_exp[i]) m_pend[i] = 1;
            else if (pick == i) m_pend[i] = 0;
        end
        if (free) begin
            if (pick >= 0) begin
                m_valid = 1; m_ch = pick; m_rr = (pick + 1) % N;
            end else begin
                m_valid = 0;
            end
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    task automatic compare_step();
        logic [N-1:0] eb;
        logic [N-1:0] eo;
        for (int i = 0; i < N; i++) begin
            eb[i] = m_run[i];
            eo[i] = m_ovr[i];
        end
        check("busy", 32'(busy), 32'(eb));
        check("evt_valid", 32'(evt_valid), 32'(m_valid));
        if (m_valid) check("evt_ch", 32'(evt_ch), 32'(m_ch));
        check("overrun", 32'(overrun), 32'(eo));
    endtask

    initial forever begin
        @(negedge clk);
        if (chk_en) compare_step();
        if (evt_valid === 1'b1 && evt_ready === 1'b1) begin
            ev_ch.push_back(int'(evt_ch));
            ev_cyc.push_back(cyc);
        end
    end

    task automatic next();
        @(posedge clk);
        #1;
        tick_in = 0; start = '0; stop = '0; cfg_we = 0; overrun_clr = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) next();
    endtask

    task automatic tick();
        tick_in = 1;
        next();
    endtask

    task automatic cfg(input int ch, input int per, input bit mode);
        cfg_ch = CHW'(ch); cfg_period = CW'(per); cfg_mode = mode; cfg_we = 1;
        next();
    endtask

    task automatic do_reset();
        rst = 1;
        next();
        rst = 0;
        ev_ch.delete();
        ev_cyc.delete();
    endtask

    int tk[10];

    initial begin
        next();
        do_reset();
        check("reset_busy", 32'(busy), 32'h0);
        check("reset_valid", 32'(evt_valid), 32'h0);
        check("reset_evt_ch", 32'(evt_ch), 32'h0);
        check("reset_overrun", 32'(overrun), 32'h0);
        chk_en = 1;

        // One-shot, period 3, ticks every 4 clk
        evt_ready = 1;
        cfg(0, 3, 0);
        start = 4'b0001; next();
        check("t1_busy_started", 32'(busy[0]), 32'h1);
        for (int k = 0; k < 3; k++) begin
            tk[k] = cyc;
            tick();
            idle(3);
        end
        check("t1_event_count", 32'(ev_ch.size()), 32'd1);
        check("t1_event_ch", 32'(ev_ch[0]), 32'd0);
        check("t1_latency", 32'(ev_cyc[0] - tk[2]), 32'd2);
        check("t1_busy_fell", 32'(busy[0]), 32'h0);
        for (int k = 0; k < 3; k++) begin tick(); idle(1); end
        check("t1_no_more", 32'(ev_ch.size()), 32'd1);

        // Periodic, period 2, ten ticks
        do_reset();
        evt_ready = 1;
        cfg(1, 2, 1);
        start = 4'b0010; next();
        for (int k = 0; k < 10; k++) begin
            tk[k] = cyc;
            tick();
            idle(1);
        end
        idle(2);
        check("t2_event_count", 32'(ev_ch.size()), 32'd5);
        for (int j = 0; j < 5; j++) begin
            check("t2_event_ch", 32'(ev_ch[j]), 32'd1);
            check("t2_event_time", 32'(ev_cyc[j] - tk[2*j+1]), 32'd2);
        end
        check("t2_busy_running", 32'(busy[1]), 32'h1);
        stop = 4'b0010; next();
        check("t2_busy_stopped", 32'(busy[1]), 32'h0);
        for (int k = 0; k < 4; k++) begin tick(); idle(1); end
        check("t2_no_more", 32'(ev_ch.size()), 32'd5);

        // All four channels period 1 periodic: round-robin order
        do_reset();
        evt_ready = 1;
        for (int c = 0; c < N; c++) cfg(c, 1, 1);
        start = 4'b1111; next();
        tick(); idle(6);
        tick(); idle(6);
        check("t3_event_count", 32'(ev_ch.size()), 32'd8);
        for (int j = 0; j < 8; j++) begin
            check("t3_order", 32'(ev_ch[j]), 32'(j % N));
            check("t3_back_to_back", 32'(ev_cyc[j] - ev_cyc[(j / N) * N]), 32'(j % N));
        end
        stop = 4'b1111; next();

        // Backpressure and overrun on ch2
        do_reset();
        evt_ready = 0;
        cfg(2, 1, 1);
        start = 4'b0100; next();
        tick(); idle(2);
        check("t4_valid_held", 32'(evt_valid), 32'h1);
        check("t4_ch_held", 32'(evt_ch), 32'd2);
        tick(); idle(2);
        check("t4_no_overrun_yet", 32'(overrun), 32'h0);
        tick(); idle(2);
        check("t4_overrun_set", 32'(overrun), 32'h4);
        check("t4_valid_still", 32'(evt_valid), 32'h1);
        check("t4_ch_still", 32'(evt_ch), 32'd2);
        overrun_clr = 1; next();
        check("t4_overrun_clr", 32'(overrun), 32'h0);
        evt_ready = 1;
        idle(4);
        check("t4_delivered", 32'(ev_ch.size()), 32'd2);
        check("t4_deliv_ch0", 32'(ev_ch[0]), 32'd2);
        check("t4_deliv_ch1", 32'(ev_ch[1]), 32'd2);
        stop = 4'b0100; next();

        // Corner: start+stop together, zero period start
        do_reset();
        evt_ready = 1;
        cfg(3, 2, 1);
        start = 4'b1000; stop = 4'b1000; next();
        check("c_start_stop", 32'(busy[3]), 32'h0);
        cfg(0, 0, 0);
        start = 4'b0001; next();
        check("c_zero_period", 32'(busy[0]), 32'h0);

        // Corner: period rewritten mid-run
        cfg(1, 2, 1);
        start = 4'b0010; next();
        tick(); idle(1);
        cfg(1, 5, 1);
        tick(); idle(2);
        check("c_reprog_first", 32'(ev_ch.size()), 32'd1);
        for (int k = 0; k < 4; k++) begin tick(); idle(1); end
        check("c_reprog_wait", 32'(ev_ch.size()), 32'd1);
        tick(); idle(2);
        check("c_reprog_second", 32'(ev_ch.size()), 32'd2);

        // Corner: reset while an event is presented
        evt_ready = 0;
        cfg(0, 1, 1);
        start = 4'b0001; next();
        tick(); idle(2);
        check("c_pre_rst_valid", 32'(evt_valid), 32'h1);
        rst = 1; next(); rst = 0;
        check("c_rst_valid", 32'(evt_valid), 32'h0);
        check("c_rst_busy", 32'(busy), 32'h0);
        check("c_rst_overrun", 32'(overrun), 32'h0);
        idle(2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/tick_scheduler.md
Name: tick_scheduler

Overview:
- Shares one base enable pulse (1-cycle `tick_in` from the clock-enable generator) among NUM_CH independent software timers.
- Each channel has its own period and mode (one-shot or periodic) and can be started and stopped at any time.
- Expiries are queued per channel and delivered on a single valid/ready event port using round-robin arbitration.
- Sits between the base tick generator and the consumers: display refresh, debounce, blink logic.

Parameters:
- NUM_CH, 4, number of timer channels (2..16).
- CNT_W, 16, width of per-channel period/count, in tick_in units.
- CH_W, $clog2(NUM_CH), width of channel index fields.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high (one clock; reset is synchronous and active-high).
- tick_in  in  1  base enable pulse, high for one clk cycle per base period.
- cfg_we  in  1  write period/mode of channel cfg_ch.
- cfg_ch  in  CH_W  channel to configure.
- cfg_period  in  CNT_W  period in ticks; 0 = channel disabled.
- cfg_mode  in  1  0 = one-shot, 1 = periodic.
- start  in  NUM_CH  per-channel start/restart strobe.
- stop  in  NUM_CH  per-channel stop strobe.
- busy  out  NUM_CH  channel running.
- evt_valid  out  1  event available.
- evt_ch  out  CH_W  channel that expired.
- evt_ready  in  1  consumer accepts event.
- overrun  out  NUM_CH  sticky: expiry lost because the previous one was still pending.
- overrun_clr  in  1  clears all overrun bits.

Behaviour:
- Reset: busy=0, evt_valid=0, evt_ch=0, overrun=0. All periods=0, modes=0, counts=0, pending=0, RR pointer=0.
- Config:
  - cfg_we updates the period/mode registers only.
  - A running count is unaffected; the new values apply at the next start or periodic reload.
- Channel FSM:
  - IDLE:
    - start[i] with period!=0 → RUN, count=period, busy=1 from next cycle.
    - start[i] with period==0 is ignored.
  - RUN, tick_in:
    - count>1 → count-1.
    - count==1 → expire.
  - Counting: the tick_in in the same cycle as start is not counted. Expiry occurs on the period-th tick_in after the start cycle.
  - Expire, periodic: count=period (current register value), stay RUN. If period was written to 0, → IDLE.
  - Expire, one-shot: → IDLE, busy=0 next cycle.
  - start[i] in RUN: restart, count=period. Any tick_in in the same cycle is ignored for that channel.
  - stop[i]: → IDLE, count=0, pending[i] cleared. Stop wins over simultaneous start and over a simultaneous expiry. An event already loaded in the output slot is not withdrawn.
- Pending / overrun:
  - Expiry sets pending[i].
  - Expiry while pending[i]=1 and pending[i] is not being loaded that cycle → overrun[i]=1 (sticky); pending stays 1, so events merge.
  - Expiry in the same cycle pending[i] is loaded into the slot → pending[i] stays 1, no overrun.
  - overrun_clr clears all bits; a simultaneous new overrun wins (bit set).
- Output slot (registered):
  - The slot is free when evt_valid=0 or (evt_valid and evt_ready).
  - When free and any pending bit is set: pick the first pending channel at or after the RR pointer (wrapping), load evt_ch, evt_valid=1 next cycle, clear that pending bit, RR pointer = chosen+1 mod NUM_CH.
  - When free and no pending bit is set: evt_valid=0 next cycle.
  - evt_valid/evt_ch hold stable while evt_valid and !evt_ready.
- Latency and throughput:
  - Expiry in cycle T → pending from T+1 → evt_valid from T+2, when the slot is free.
  - With evt_ready held high, one event per cycle.
- Mid-operation rst: everything returns to reset values on the next edge; in-flight events are discarded.

Decomposition:
- Package tick_sched_pkg holds:
  - MODE_ONESHOT=0, MODE_PERIODIC=1.
  - Channel state enum {CH_IDLE, CH_RUN}.
  - A round-robin find-first-from-pointer function.
- One sub-module, tick_channel, holds per-channel period/mode/count/FSM and outputs busy and expire. It is instantiated NUM_CH times.
- Pending bits, arbiter, output slot and overrun logic live in the top level.

Test Plan:
- Ch0 period=3 one-shot, start, tick_in every 4 clk → evt_valid with evt_ch=0 exactly 2 clk after the 3rd tick; busy[0] falls after expiry; no further events.
- Ch1 period=2 periodic, evt_ready=1, 10 ticks → 5 events on ch1, each 2 clk after the even ticks; busy[1] stays 1; stop[1] → no more events, busy[1]=0.
- Ch0..3 all period=1 periodic, same start, evt_ready=1 → first tick yields evt_ch order 0,1,2,3 on consecutive cycles; second round continues from the pointer, order 0,1,2,3.
- evt_ready=0, ch2 period=1 periodic, 3 ticks → evt_valid/evt_ch=2 held stable; overrun[2]=1 after the 3rd tick; overrun_clr → 0; release ready → exactly 2 ch2 events delivered.
- Corner cases:
  - start and stop on ch3 in the same cycle → stays IDLE.
  - cfg_period=0 then start → busy stays 0.
  - cfg_we period=5 mid-run on a periodic channel with period=2 → current expiry still after 2 ticks, next after 5.
  - rst asserted with evt_valid=1 → evt_valid=0, busy=0, overrun=0 next cycle.
